// File: rtl/circuit1_sequencer_pkg.sv
// Shared definitions for the circuit1 sequencer: FSM states, ALU op codes
// and the default operand width.
// Imported by circuit1_sequencer and shared_alu.
package circuit1_sequencer_pkg;

   localparam int DATAWIDTH_DEF = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADD_AB = 3'd1,
      ADD_AC = 3'd2,
      MUL_AC = 3'd3,
      SUB_FD = 3'd4,
      DONE   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_GT  = 2'd2
   } alu_op_t;

endpackage

// File: rtl/circuit1_sequencer_alu.sv
// shared_alu: combinational add / subtract / unsigned greater-than unit.
// Latency: none (pure combinational). Backpressure: none.
// Ports: op_i selects the function, a_i/b_i operands, res_o op-selected
//        result (modulo 2^W), gt_o the (a_i > b_i) flag, valid for every op.
module shared_alu
   import circuit1_sequencer_pkg::*;
#(
   parameter int W = 2 * DATAWIDTH_DEF
) (
   input  alu_op_t        op_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [W-1:0]   res_o,
   output logic           gt_o
);

   // The comparator is exposed on its own so the sequencer can capture the
   // sum and the compare flag in the same cycle with one unit.
   assign gt_o = (a_i > b_i);

   always_comb begin
      res_o = '0;
      case (op_i)
         OP_ADD:  res_o = a_i + b_i;
         OP_SUB:  res_o = a_i - b_i;
         OP_GT:   res_o = {{(W-1){1'b0}}, gt_o};
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/circuit1_sequencer.sv
// circuit1_sequencer: computes d=a+b, e=a+c, g=(a>b), f=a*c, x=f-d and
// z=(e!=0)?d:g over five states with one shared ALU and one multiplier.
// Latency: start accepted at edge N -> done high in the cycle after edge N+4.
// Backpressure: none; start is only sampled in IDLE, ignored otherwise.
// Ports: Clk, Rst (sync, active-high), start, a/b/c operands in;
//        busy, done pulse, z (DATAWIDTH) and x (2*DATAWIDTH) results out.
module circuit1_sequencer
   import circuit1_sequencer_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     start,
   input  logic [DATAWIDTH-1:0]     a,
   input  logic [DATAWIDTH-1:0]     b,
   input  logic [DATAWIDTH-1:0]     c,
   output logic                     busy,
   output logic                     done,
   output logic [DATAWIDTH-1:0]     z,
   output logic [2*DATAWIDTH-1:0]   x
);

   localparam int DW = DATAWIDTH;
   localparam int XW = 2 * DATAWIDTH;

   state_t          state_q, state_d;
   logic [DW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic [DW-1:0]   d_q, d_d, e_q, e_d;
   logic            g_q, g_d;
   logic [XW-1:0]   f_q, f_d;
   logic [DW-1:0]   z_q, z_d;
   logic [XW-1:0]   x_q, x_d;

   alu_op_t         alu_op;
   logic [XW-1:0]   alu_a, alu_b, alu_res;
   logic            alu_gt;
   logic [XW-1:0]   mul_prod;

   shared_alu #(.W(XW)) u_alu (
      .op_i  (alu_op),
      .a_i   (alu_a),
      .b_i   (alu_b),
      .res_o (alu_res),
      .gt_o  (alu_gt)
   );

   // Operands are widened before the multiply so the full product is kept.
   assign mul_prod = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, c_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      e_d     = e_q;
      g_d     = g_q;
      f_d     = f_q;
      z_d     = z_q;
      x_d     = x_q;
      alu_op  = OP_ADD;
      alu_a   = '0;
      alu_b   = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               c_d     = c;
               state_d = ADD_AB;
            end
         end
         ADD_AB: begin
            // Sum and compare come from the same ALU evaluation.
            alu_op  = OP_ADD;
            alu_a   = {{DW{1'b0}}, a_q};
            alu_b   = {{DW{1'b0}}, b_q};
            d_d     = alu_res[DW-1:0];
            g_d     = alu_gt;
            state_d = ADD_AC;
         end
         ADD_AC: begin
            alu_op  = OP_ADD;
            alu_a   = {{DW{1'b0}}, a_q};
            alu_b   = {{DW{1'b0}}, c_q};
            e_d     = alu_res[DW-1:0];
            state_d = MUL_AC;
         end
         MUL_AC: begin
            f_d     = mul_prod;
            state_d = SUB_FD;
         end
         SUB_FD: begin
            alu_op  = OP_SUB;
            alu_a   = f_q;
            alu_b   = {{DW{1'b0}}, d_q};
            x_d     = alu_res;
            z_d     = (e_q != '0) ? d_q : {{(DW-1){1'b0}}, g_q};
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         e_q     <= '0;
         g_q     <= 1'b0;
         f_q     <= '0;
         z_q     <= '0;
         x_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         e_q     <= e_d;
         g_q     <= g_d;
         f_q     <= f_d;
         z_q     <= z_d;
         x_q     <= x_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign z    = z_q;
   assign x    = x_q;

endmodule

// File: doc/circuit1_sequencer.md
CIRCUIT1_SEQUENCER -- requirements
Module: circuit1_sequencer

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the operand width; product and x width are 2*DATAWIDTH.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request one computation; sampled only in IDLE.
REQ-005 The block SHALL have ports a, b, c, input, DATAWIDTH bits each: unsigned operands, sampled on the accepting edge.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid z and x.
REQ-008 The block SHALL have port z, output, DATAWIDTH bits: mux result.
REQ-009 The block SHALL have port x, output, 2*DATAWIDTH bits: product-minus-sum result.

Function
REQ-010 The block SHALL compute d=a+b, e=a+c, g=(a>b), f=a*c, x=f-d and z=(e!=0)?d:g, using one shared add/sub/compare unit and one multiplier.
REQ-011 The FSM SHALL use states IDLE, ADD_AB, ADD_AC, MUL_AC, SUB_FD and DONE.
REQ-012 IDLE SHALL go to ADD_AB when start=1, latching a, b, c into internal registers; with start=0 it SHALL stay in IDLE.
REQ-013 ADD_AB SHALL latch d=(a+b) mod 2^DATAWIDTH and g=(a>b) unsigned, then go to ADD_AC.
REQ-014 ADD_AC SHALL latch e=(a+c) mod 2^DATAWIDTH, then go to MUL_AC.
REQ-015 MUL_AC SHALL latch the full 2*DATAWIDTH-bit f=a*c, then go to SUB_FD.
REQ-016 SUB_FD SHALL load x=(f - zero-extended d) mod 2^(2*DATAWIDTH) and z=(e!=0)?d:zero-extended g, then go to DONE.
REQ-017 DONE SHALL assert done=1 for exactly that cycle, then go to IDLE.
REQ-018 Latency SHALL be 5 cycles: start accepted at edge N gives done=1 during the cycle after edge N+4.
REQ-019 A start in any state other than IDLE, including DONE, SHALL be ignored.
REQ-020 Operand input changes after acceptance SHALL not affect the result in progress.
REQ-021 z and x SHALL hold their last values until the next SUB_FD, or until reset.
REQ-022 Back-to-back: start held high SHALL be accepted in the IDLE cycle after DONE, one result per 6 cycles.

Reset
REQ-023 When Rst=1 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, z=0, x=0 and all internal registers at 0.
REQ-024 Rst SHALL take priority over start and over every state transition.
REQ-025 Rst asserted mid-operation SHALL abort the operation with no done pulse; a start is accepted the first cycle Rst=0 in IDLE.

Structure
REQ-026 A shared package SHALL hold the state enumeration, the ALU op codes (OP_ADD, OP_SUB, OP_GT) and the DATAWIDTH default.
REQ-027 The block SHALL instantiate one sub-module, shared_alu, a combinational add/sub/greater-than unit of width 2*DATAWIDTH, selected by op code.
REQ-028 The multiplier SHALL be inline combinational logic registered in MUL_AC; no other arithmetic units are permitted.

Verification
REQ-029 Directed test: a=5, b=3, c=2, start pulse -> done after 5 cycles, z=8, x=2.
REQ-030 Directed test: a=0, b=0, c=0 -> e=0 selects g, so z=0, x=0.
REQ-031 Directed test: a=200, b=100, c=56 -> d wraps to 44, e wraps to 0, so z=1, x=11156.
REQ-032 Directed test: a=1, b=10, c=1 -> negative difference wraps, x=65526, z=11.
REQ-033 Directed test: Rst pulsed during MUL_AC -> no done, z=0, x=0, IDLE next cycle; a following run with a=5, b=3, c=2 gives z=8, x=2.
REQ-034 Directed test: start held high continuously -> done pulses every 6 cycles, busy low only in IDLE cycles, extra starts during busy ignored.
